// File: rtl/reg_writeback_ctrl_pkg.sv
// Shared definitions for the register-file write-back slice: widths and
// the write-source encoding used by the port arbiter.
package rv_pkg;
   localparam int XLEN     = 32;
   localparam int AW       = 5;
   localparam int NUM_REGS = 32;

   typedef enum logic [1:0] {
      WB_NONE,
      WB_ALU,
      WB_MEM
   } wb_src_t;
endpackage

// File: rtl/reg_writeback_ctrl_if.sv
// Memory-result handshake: the load unit offers {rd, data}; the
// write-back controller accepts it with mem_ready.
interface mem_if #(
   parameter int XLEN = rv_pkg::XLEN,
   parameter int AW   = rv_pkg::AW
);
   logic            mem_valid;
   logic            mem_ready;
   logic [AW-1:0]   mem_rd;
   logic [XLEN-1:0] mem_data;

   modport master (output mem_valid, output mem_rd, output mem_data, input mem_ready);
   modport slave  (input mem_valid, input mem_rd, input mem_data, output mem_ready);
endinterface

// File: rtl/reg_writeback_ctrl_wb_fifo.sv
// Small synchronous FIFO holding pending memory results as {rd, data}.
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 37
) (
   input  logic                       CLK,
   input  logic                       areset,
   input  logic                       push,
   input  logic [W-1:0]               din,
   input  logic                       pop,
   output logic [W-1:0]               dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  store [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   assign full  = (count == (PW+1)'(DEPTH));
   assign empty = (count == '0);
   assign dout  = store[rd_ptr];

   always_ff @(posedge CLK) begin
      if (push) store[wr_ptr] <= din;
   end

   always_ff @(posedge CLK or negedge areset) begin
      if (!areset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/reg_writeback_ctrl.sv
// Merges ALU and memory results onto the single register-file write port
// and tracks destinations with outstanding loads for hazard detection.
module reg_writeback_ctrl
   import rv_pkg::*;
#(
   parameter int XLEN  = rv_pkg::XLEN,
   parameter int AW    = rv_pkg::AW,
   parameter int DEPTH = 2
) (
   input  logic                    CLK,
   input  logic                    areset,
   input  logic                    alu_valid,
   input  logic [AW-1:0]           alu_rd,
   input  logic [XLEN-1:0]         alu_data,
   mem_if.slave                    mem,
   input  logic                    lsu_issue,
   input  logic [AW-1:0]           lsu_issue_rd,
   input  logic [AW-1:0]           chk_rs1,
   input  logic [AW-1:0]           chk_rs2,
   input  logic [AW-1:0]           chk_rd,
   output logic                    hazard,
   output logic                    WE3,
   output logic [AW-1:0]           A3,
   output logic [XLEN-1:0]         WD3,
   output logic [$clog2(DEPTH):0]  pend_count
);
   localparam int NREGS = 1 << AW;

   wb_src_t             src;
   logic [AW-1:0]       nrd;
   logic [XLEN-1:0]     ndata;
   logic                from_fifo;
   logic                bypass;
   logic                f_push;
   logic                f_full;
   logic                f_empty;
   logic [AW+XLEN-1:0]  f_dout;
   logic [NREGS-1:0]    busy;
   logic [NREGS-1:0]    busy_n;

   wb_fifo #(.DEPTH(DEPTH), .W(AW + XLEN)) u_fifo (
      .CLK   (CLK),
      .areset(areset),
      .push  (f_push),
      .din   ({mem.mem_rd, mem.mem_data}),
      .pop   (from_fifo),
      .dout  (f_dout),
      .full  (f_full),
      .empty (f_empty),
      .count (pend_count)
   );

   assign mem.mem_ready = !f_full;

   // ALU first, then queued memory results, then a direct bypass when idle.
   always_comb begin
      src       = WB_NONE;
      nrd       = '0;
      ndata     = '0;
      from_fifo = 1'b0;
      bypass    = 1'b0;
      if (alu_valid && alu_rd != '0) begin
         src   = WB_ALU;
         nrd   = alu_rd;
         ndata = alu_data;
      end else if (!f_empty) begin
         src          = WB_MEM;
         {nrd, ndata} = f_dout;
         from_fifo    = 1'b1;
      end else if (mem.mem_valid && mem.mem_rd != '0) begin
         src    = WB_MEM;
         nrd    = mem.mem_rd;
         ndata  = mem.mem_data;
         bypass = 1'b1;
      end
   end

   // x0 transfers are accepted by the handshake but never queued.
   assign f_push = mem.mem_valid && !f_full && (mem.mem_rd != '0) && !bypass;

   always_comb begin
      busy_n = busy;
      if (src == WB_MEM) busy_n[nrd] = 1'b0;
      if (lsu_issue && lsu_issue_rd != '0) busy_n[lsu_issue_rd] = 1'b1;
      busy_n[0] = 1'b0;
   end

   always_ff @(posedge CLK or negedge areset) begin
      if (!areset) begin
         busy <= '0;
         WE3  <= 1'b0;
         A3   <= '0;
         WD3  <= '0;
      end else begin
         busy <= busy_n;
         WE3  <= (src != WB_NONE);
         if (src != WB_NONE) begin
            A3  <= nrd;
            WD3 <= ndata;
         end
      end
   end

   function automatic logic reg_hz(input logic [AW-1:0] a);
      return (a != '0) && (busy[a] || (WE3 && A3 == a));
   endfunction

   assign hazard = reg_hz(chk_rs1) || reg_hz(chk_rs2) || reg_hz(chk_rd);
endmodule
